// File: rtl/exc_pkg.sv
// Shared constants for the exception-carry pipeline: ExcCode width and the
// CP0 Cause.ExcCode values used by the core.
package exc_pkg;

  localparam int unsigned EXC_CODE_W = 5;

  localparam logic [EXC_CODE_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_CODE_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_CODE_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_CODE_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_CODE_W-1:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/exc_slot_reg.sv
// One pipeline-boundary exception slot: merges the carried exception with a new
// detection, then registers it with reset > flush > hold > load. EXC_PC_TRACK_EN adds {pc, bd}.
module exc_slot_reg
  import exc_pkg::*;
#(
  parameter int unsigned CODE_W   = EXC_CODE_W,
  parameter int unsigned NEW_WINS = 0
`ifdef EXC_PC_TRACK_EN
  ,
  parameter int unsigned PC_W     = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  input  logic              det_valid,
  input  logic [CODE_W-1:0] det_code,
`ifdef EXC_PC_TRACK_EN
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_bd,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              bd_in,
  output logic [PC_W-1:0]   slot_pc,
  output logic              slot_bd,
`endif
  output logic              slot_valid,
  output logic [CODE_W-1:0] slot_code
);

  logic              use_in;
  logic              m_valid;
  logic [CODE_W-1:0] m_code;
  logic              valid_d, valid_q;
  logic [CODE_W-1:0] code_d, code_q;
`ifdef EXC_PC_TRACK_EN
  logic [PC_W-1:0]   m_pc, pc_d, pc_q;
  logic              m_bd, bd_d, bd_q;
`endif

  // use_in: the carried exception survives the merge
  always_comb begin
    use_in  = in_valid & ~((NEW_WINS != 0) & det_valid);
    m_valid = in_valid | det_valid;
    m_code  = '0;
    if (use_in)
      m_code = in_code;
    else if (det_valid)
      m_code = det_code;
  end

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    if (reset || flush) begin
      valid_d = 1'b0;
      code_d  = '0;
    end else if (!hold) begin
      valid_d = m_valid;
      code_d  = m_code;
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    code_q  <= code_d;
  end

  assign slot_valid = valid_q;
  assign slot_code  = code_q;

`ifdef EXC_PC_TRACK_EN
  // Without a surviving carried exception the slot tracks this stage's PC, so interrupts get an EPC.
  always_comb begin
    m_pc = use_in ? in_pc : pc_in;
    m_bd = use_in ? in_bd : bd_in;
    pc_d = pc_q;
    bd_d = bd_q;
    if (reset || flush) begin
      pc_d = '0;
      bd_d = 1'b0;
    end else if (!hold) begin
      pc_d = m_pc;
      bd_d = m_bd;
    end
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    bd_q <= bd_d;
  end

  assign slot_pc = pc_q;
  assign slot_bd = bd_q;
`endif

endmodule

// File: rtl/exc_pipe_chain.sv
// Exception-carry pipeline for the 5-stage core: NSTAGE chained exception slots feeding CP0.
// Optional EXC_PC_TRACK_EN carries PC/branch-delay state and produces EPC/Cause.BD.
module exc_pipe_chain
  import exc_pkg::*;
#(
  parameter int unsigned NSTAGE   = 4,
  parameter int unsigned CODE_W   = EXC_CODE_W,
  parameter int unsigned NEW_WINS = 0,
  parameter int unsigned PC_W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NSTAGE-1:0]        hold,
  input  logic [NSTAGE-1:0]        flush,
  input  logic [NSTAGE-1:0]        det_valid,
  input  logic [NSTAGE*CODE_W-1:0] det_code,
`ifdef EXC_PC_TRACK_EN
  input  logic [NSTAGE*PC_W-1:0]   pc_in,
  input  logic [NSTAGE-1:0]        bd_in,
  output logic [PC_W-1:0]          exc_epc,
  output logic                     exc_bd,
`endif
  output logic [NSTAGE-1:0]        slot_valid,
  output logic [NSTAGE*CODE_W-1:0] slot_code,
  output logic                     exc_take,
  output logic [CODE_W-1:0]        exc_code,
  output logic                     exc_pending
);

  if (NSTAGE < 2 || PC_W < 3) begin : g_param_chk
    $error("exc_pipe_chain: NSTAGE must be >= 2 and PC_W >= 3");
  end

`ifdef EXC_PC_TRACK_EN
  logic [NSTAGE*PC_W-1:0] slot_pc;
  logic [NSTAGE-1:0]      slot_bd;
`endif

  for (genvar i = 0; i < NSTAGE; i++) begin : g_slot
    logic              up_valid;
    logic [CODE_W-1:0] up_code;
`ifdef EXC_PC_TRACK_EN
    logic [PC_W-1:0]   up_pc;
    logic              up_bd;
`endif

    // Slot 0 has no upstream: its carried input is a permanent bubble.
    if (i == 0) begin : g_head
      assign up_valid = 1'b0;
      assign up_code  = '0;
`ifdef EXC_PC_TRACK_EN
      assign up_pc    = '0;
      assign up_bd    = 1'b0;
`endif
    end else begin : g_body
      assign up_valid = slot_valid[i-1];
      assign up_code  = slot_code[(i-1)*CODE_W +: CODE_W];
`ifdef EXC_PC_TRACK_EN
      assign up_pc    = slot_pc[(i-1)*PC_W +: PC_W];
      assign up_bd    = slot_bd[i-1];
`endif
    end

    exc_slot_reg #(
      .CODE_W   (CODE_W),
      .NEW_WINS (NEW_WINS)
`ifdef EXC_PC_TRACK_EN
      ,
      .PC_W     (PC_W)
`endif
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .hold       (hold[i]),
      .flush      (flush[i]),
      .in_valid   (up_valid),
      .in_code    (up_code),
      .det_valid  (det_valid[i]),
      .det_code   (det_code[i*CODE_W +: CODE_W]),
`ifdef EXC_PC_TRACK_EN
      .in_pc      (up_pc),
      .in_bd      (up_bd),
      .pc_in      (pc_in[i*PC_W +: PC_W]),
      .bd_in      (bd_in[i]),
      .slot_pc    (slot_pc[i*PC_W +: PC_W]),
      .slot_bd    (slot_bd[i]),
`endif
      .slot_valid (slot_valid[i]),
      .slot_code  (slot_code[i*CODE_W +: CODE_W])
    );
  end

  assign exc_take    = slot_valid[NSTAGE-1];
  assign exc_code    = slot_code[(NSTAGE-1)*CODE_W +: CODE_W];
  assign exc_pending = |slot_valid[NSTAGE-2:0];

`ifdef EXC_PC_TRACK_EN
  // A branch-delay-slot exception restarts at the branch, one word back.
  assign exc_bd  = slot_bd[NSTAGE-1];
  assign exc_epc = exc_bd ? slot_pc[(NSTAGE-1)*PC_W +: PC_W] - PC_W'(4)
                          : slot_pc[(NSTAGE-1)*PC_W +: PC_W];
`endif

endmodule

// File: tb/tb_exc_pipe_chain.sv
// Directed bench for exc_pipe_chain (NSTAGE=4): one instance per priority mode
// sharing stimulus; EPC checks are included when EXC_PC_TRACK_EN is defined.
module tb_exc_pipe_chain;
  import exc_pkg::*;

  localparam int NS = 4;
  localparam int CW = 5;
  localparam int PW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [NS-1:0]   hold, flush, det_valid;
  logic [NS*CW-1:0] det_code;
  logic [NS-1:0]   slot_valid, slot_valid_nw;
  logic [NS*CW-1:0] slot_code, slot_code_nw;
  logic            exc_take, exc_take_nw, exc_pending, exc_pending_nw;
  logic [CW-1:0]   exc_code, exc_code_nw;
`ifdef EXC_PC_TRACK_EN
  logic [NS*PW-1:0] pc_in;
  logic [NS-1:0]   bd_in;
  logic [PW-1:0]   exc_epc, exc_epc_nw;
  logic            exc_bd, exc_bd_nw;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exc_pipe_chain #(.NSTAGE(NS), .CODE_W(CW), .NEW_WINS(0), .PC_W(PW)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .det_valid(det_valid), .det_code(det_code),
`ifdef EXC_PC_TRACK_EN
    .pc_in(pc_in), .bd_in(bd_in), .exc_epc(exc_epc), .exc_bd(exc_bd),
`endif
    .slot_valid(slot_valid), .slot_code(slot_code),
    .exc_take(exc_take), .exc_code(exc_code), .exc_pending(exc_pending)
  );

  exc_pipe_chain #(.NSTAGE(NS), .CODE_W(CW), .NEW_WINS(1), .PC_W(PW)) dut_nw (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .det_valid(det_valid), .det_code(det_code),
`ifdef EXC_PC_TRACK_EN
    .pc_in(pc_in), .bd_in(bd_in), .exc_epc(exc_epc_nw), .exc_bd(exc_bd_nw),
`endif
    .slot_valid(slot_valid_nw), .slot_code(slot_code_nw),
    .exc_take(exc_take_nw), .exc_code(exc_code_nw), .exc_pending(exc_pending_nw)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic det(input int i, input logic [CW-1:0] code);
    det_valid[i] = 1'b1;
    det_code[i*CW +: CW] = code;
  endtask

  task automatic idle();
    hold = '0; flush = '0; det_valid = '0; det_code = '0;
  endtask

  initial begin
    reset = 1'b1;
    hold = '0; flush = '0;
    det_valid = '1;
    det_code = {5'd12, 5'd10, 5'd5, 5'd4};
`ifdef EXC_PC_TRACK_EN
    pc_in = '0; bd_in = '0;
`endif
    // Reset with detections present
    tick(); tick();
    chk("rst_valid",   64'(slot_valid), 64'h0);
    chk("rst_code",    64'(slot_code), 64'h0);
    chk("rst_take",    64'(exc_take), 64'h0);
    chk("rst_exccode", 64'(exc_code), 64'h0);
    chk("rst_pending", 64'(exc_pending), 64'h0);
    chk("rst_valid_nw", 64'(slot_valid_nw), 64'h0);
    reset = 1'b0;
    idle();
    tick();

    // det_code alone must not create a nonzero stored code
    det_code = {5'd31, 5'd31, 5'd31, 5'd31};
    tick();
    chk("ign_code",  64'(slot_code), 64'h0);
    chk("ign_valid", 64'(slot_valid), 64'h0);
    idle();

    // Single RI at stage 1: exc_take 3 cycles later, for 1 cycle
    det(1, EXC_RI);
    tick(); idle();
    chk("single_e1_take", 64'(exc_take), 64'h0);
    chk("single_e1_pend", 64'(exc_pending), 64'h1);
    chk("single_e1_s1",   64'(slot_code[1*CW +: CW]), 64'd10);
    tick();
    chk("single_e2_take", 64'(exc_take), 64'h0);
    tick();
    chk("single_e3_take", 64'(exc_take), 64'h1);
    chk("single_e3_code", 64'(exc_code), 64'd10);
    chk("single_e3_pend", 64'(exc_pending), 64'h0);
    tick();
    chk("single_e4_take", 64'(exc_take), 64'h0);

    // Priority: AdEL at stage 0, then RI at stage 1 one cycle later
    det(0, EXC_ADEL);
    tick(); idle();
    det(1, EXC_RI);
    tick(); idle();
    chk("prio_s1_old", 64'(slot_code[1*CW +: CW]), 64'd4);
    chk("prio_s1_new", 64'(slot_code_nw[1*CW +: CW]), 64'd10);
    tick(); tick();
    chk("prio_take_old", 64'(exc_take), 64'h1);
    chk("prio_code_old", 64'(exc_code), 64'd4);
    chk("prio_take_new", 64'(exc_take_nw), 64'h1);
    chk("prio_code_new", 64'(exc_code_nw), 64'd10);
    tick();

    // Hold slot 2 with OV for 3 cycles while slot 3 is flushed
    det(2, EXC_OV);
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      hold[2] = 1'b1; flush[3] = 1'b1;
      tick();
      chk("hold_s2_valid", 64'(slot_valid[2]), 64'h1);
      chk("hold_s2_code",  64'(slot_code[2*CW +: CW]), 64'd12);
      chk("hold_take",     64'(exc_take), 64'h0);
    end
    idle();
    tick();
    chk("rel_take", 64'(exc_take), 64'h1);
    chk("rel_code", 64'(exc_code), 64'd12);
    chk("rel_s2",   64'(slot_valid[2]), 64'h0);
    tick();

    // Flush and detection on slot 1 in the same cycle: detection lost
    det(1, EXC_ADES);
    flush[1] = 1'b1;
    tick(); idle();
    chk("coll_s1_valid", 64'(slot_valid[1]), 64'h0);
    chk("coll_s1_code",  64'(slot_code[1*CW +: CW]), 64'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("coll_take", 64'(exc_take), 64'h0);
    end

    // Detection at the last stage reaches exc_take in 1 cycle
    det(3, EXC_OV);
    tick(); idle();
    chk("last_take", 64'(exc_take), 64'h1);
    chk("last_code", 64'(exc_code), 64'd12);
    tick();
    chk("last_after", 64'(exc_take), 64'h0);

    // Reset during a hold clears the held slot
    det(2, EXC_ADEL);
    tick(); idle();
    chk("mid_pre", 64'(slot_valid[2]), 64'h1);
    hold = '1; reset = 1'b1;
    tick();
    chk("mid_valid", 64'(slot_valid), 64'h0);
    chk("mid_code",  64'(slot_code), 64'h0);
    reset = 1'b0; idle();
    tick();

`ifdef EXC_PC_TRACK_EN
    // OV in a branch-delay slot at stage 2: EPC points at the branch
    det(2, EXC_OV);
    pc_in[2*PW +: PW] = 32'h3010;
    bd_in[2] = 1'b1;
    tick(); idle();
    pc_in = '0; bd_in = '0;
    tick();
    chk("pc_take", 64'(exc_take), 64'h1);
    chk("pc_epc",  64'(exc_epc), 64'h300C);
    chk("pc_bd",   64'(exc_bd), 64'h1);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
